// File: rtl/turn_signal_conditioner.sv
// Turn-stalk front end: synchronises and debounces both switches, paces sequencer
// frames with step_en, and arbitrates mutually exclusive left/right requests.
module turn_signal_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_CYCLES     = 8,
    parameter int SEQ_STEPS       = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    output logic step_en,
    output logic left,
    output logic right,
    output logic left_db,
    output logic right_db,
    output logic conflict
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
    localparam int DIVW = $clog2(STEP_CYCLES);
    localparam int SCW  = $clog2(SEQ_STEPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_L = 2'd1,
        GRANT_R = 2'd2
    } state_t;

    // Channel index 0 is the left switch, 1 is the right switch.
    logic [1:0]          sync1_q;
    logic [1:0]          sync2_q;
    logic [1:0][DBW-1:0] dbcnt_q;
    logic [1:0][DBW-1:0] dbcnt_d;
    logic [1:0]          db_q;
    logic [1:0]          db_d;

    logic [DIVW-1:0]     div_q;
    logic [DIVW-1:0]     div_d;
    logic                step_w;

    state_t              state_q;
    state_t              state_d;
    logic [SCW-1:0]      scnt_q;
    logic [SCW-1:0]      scnt_d;
    logic                left_q;
    logic                right_q;
    logic                conflict_q;

    logic                want_l;
    logic                want_r;
    logic                seq_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {right_sw, left_sw};
            sync2_q <= sync1_q;
        end
    end

    // A change must survive DEBOUNCE_CYCLES consecutive sampled cycles to be accepted.
    always_comb begin
        dbcnt_d = '0;
        db_d    = db_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dbcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbcnt_d[i] = dbcnt_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbcnt_q <= '0;
            db_q    <= '0;
        end else begin
            dbcnt_q <= dbcnt_d;
            db_q    <= db_d;
        end
    end

    assign step_w = (div_q == DIVW'(STEP_CYCLES - 1));

    always_comb begin
        div_d = div_q + DIVW'(1);
        if (step_w) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign want_l   = db_q[0] & ~db_q[1];
    assign want_r   = db_q[1] & ~db_q[0];
    assign seq_last = (scnt_q == SCW'(SEQ_STEPS - 1));

    // Grants are only reconsidered at a sequence boundary, so a reversal always passes through IDLE.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        if (step_w) begin
            case (state_q)
                IDLE: begin
                    if (want_l) begin
                        state_d = GRANT_L;
                        scnt_d  = '0;
                    end else if (want_r) begin
                        state_d = GRANT_R;
                        scnt_d  = '0;
                    end
                end
                GRANT_L: begin
                    if (!seq_last) begin
                        scnt_d = scnt_q + SCW'(1);
                    end else if (want_l) begin
                        scnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        scnt_d  = '0;
                    end
                end
                GRANT_R: begin
                    if (!seq_last) begin
                        scnt_d = scnt_q + SCW'(1);
                    end else if (want_r) begin
                        scnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        scnt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    scnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            scnt_q     <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            left_q     <= (state_d == GRANT_L);
            right_q    <= (state_d == GRANT_R);
            conflict_q <= db_q[0] & db_q[1];
        end
    end

    assign step_en  = step_w;
    assign left     = left_q;
    assign right    = right_q;
    assign left_db  = db_q[0];
    assign right_db = db_q[1];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Randomised bench for turn_signal_conditioner against a cycle-level behavioural model
// built from delay lines, sample histories and a sequence-remaining count.
module tb_turn_signal_conditioner;

    localparam int DB = 4;
    localparam int ST = 4;
    localparam int SQ = 4;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic left_sw  = 1'b0;
    logic right_sw = 1'b0;
    logic step_en;
    logic left;
    logic right;
    logic left_db;
    logic right_db;
    logic conflict;

    int n_checks = 0;
    int n_fail   = 0;

    turn_signal_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .STEP_CYCLES    (ST),
        .SEQ_STEPS      (SQ)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .left_sw (left_sw),
        .right_sw(right_sw),
        .step_en (step_en),
        .left    (left),
        .right   (right),
        .left_db (left_db),
        .right_db(right_db),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    // Model state: pin delay line (bit1 oldest), sampled history (bit0 newest),
    // debounced levels, edges since reset, granted direction and steps left in sequence.
    bit [1:0]  m_pdel [2];
    bit [63:0] m_hist [2];
    int        m_nval [2];
    bit [1:0]  m_db;
    bit        m_conf;
    int        m_k;
    int        m_dir;      // 0 none, 1 left, 2 right
    int        m_rem;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pdel[c] = '0;
            m_hist[c] = '0;
            m_nval[c] = 0;
        end
        m_db   = '0;
        m_conf = 1'b0;
        m_k    = 0;
        m_dir  = 0;
        m_rem  = 0;
    endfunction

    function automatic void model_edge(input bit pl, input bit pr);
        bit [1:0] pins;
        bit [1:0] old_db;
        bit       stp;
        bit       smp;
        bit       all_diff;
        bit       keep;
        pins   = {pr, pl};
        old_db = m_db;
        stp    = ((m_k % ST) == ST - 1);
        for (int c = 0; c < 2; c++) begin
            smp       = m_pdel[c][1];
            m_pdel[c] = {m_pdel[c][0], pins[c]};
            m_hist[c] = {m_hist[c][62:0], smp};
            if (m_nval[c] < 64) m_nval[c]++;
            all_diff = (m_nval[c] >= DB);
            for (int i = 0; i < DB; i++) begin
                if (m_hist[c][i] == old_db[c]) all_diff = 1'b0;
            end
            if (all_diff) m_db[c] = smp;
        end
        m_conf = old_db[0] & old_db[1];
        m_k++;
        if (stp) begin
            if (m_dir == 0) begin
                if (old_db[0] && !old_db[1]) begin
                    m_dir = 1;
                    m_rem = SQ;
                end else if (old_db[1] && !old_db[0]) begin
                    m_dir = 2;
                    m_rem = SQ;
                end
            end else if (m_rem == 1) begin
                keep = (m_dir == 1) ? (old_db[0] && !old_db[1]) : (old_db[1] && !old_db[0]);
                if (keep) m_rem = SQ;
                else m_dir = 0;
            end else begin
                m_rem--;
            end
        end
    endfunction

    task automatic compare_all();
        check_eq("step_en",  step_en,  ((m_k % ST) == ST - 1));
        check_eq("left_db",  left_db,  m_db[0]);
        check_eq("right_db", right_db, m_db[1]);
        check_eq("conflict", conflict, m_conf);
        check_eq("left",     left,     (m_dir == 1));
        check_eq("right",    right,    (m_dir == 2));
    endtask

    task automatic run_cycle(input bit l, input bit r);
        left_sw  = l;
        right_sw = r;
        @(posedge clk);
        model_edge(l, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input bit l, input bit r, input int n);
        for (int i = 0; i < n; i++) run_cycle(l, r);
    endtask

    // Reset lands between edges to exercise the asynchronous path.
    task automatic do_reset(input int ncyc);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            compare_all();
        end
        reset = 1'b1;
    endtask

    task automatic glitch_train(input bit on_right, input int reps);
        int hi;
        int lo;
        for (int i = 0; i < reps; i++) begin
            hi = $urandom_range(1, DB);
            lo = $urandom_range(1, DB);
            hold(!on_right, on_right, hi);
            hold(1'b0, 1'b0, lo);
        end
    endtask

    initial begin
        int mode;
        int len;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_all();
        end
        reset = 1'b1;

        hold(1'b0, 1'b0, 9);
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 1'b0, 3);
            hold(1'b0, 1'b0, 3);
        end
        hold(1'b1, 1'b0, 80);
        hold(1'b0, 1'b0, 6);
        hold(1'b1, 1'b0, 40);
        hold(1'b0, 1'b1, 60);
        hold(1'b1, 1'b1, 50);
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b1, 40);
        hold(1'b1, 1'b0, 40);
        hold(1'b0, 1'b1, 45);
        do_reset(3);
        hold(1'b0, 1'b1, 30);

        for (int seg = 0; seg < 70; seg++) begin
            mode = $urandom_range(0, 7);
            len  = $urandom_range(5, 70);
            case (mode)
                0: hold(1'b1, 1'b0, len);
                1: hold(1'b0, 1'b1, len);
                2: hold(1'b1, 1'b1, len);
                3: hold(1'b0, 1'b0, len);
                4: for (int i = 0; i < len; i++)
                       run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                5: glitch_train(1'($urandom_range(0, 1)), $urandom_range(2, 6));
                6: do_reset($urandom_range(1, 4));
                default: begin
                    hold(1'b1, 1'b0, len);
                    hold(1'b0, 1'b1, len);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
